// File: rtl/debug_disp_pkg.sv
// Shared constants for the debug display controller: register map, CTRL bits, digit sizes.
// Also holds the small helpers for the message length and the scroll index.
package debug_disp_pkg;

    localparam int DIGITS    = 6;
    localparam int SEG_W     = 7;
    localparam int MSG_DEPTH = 16;
    localparam int IDX_W     = 4;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] ADDR_CTRL   = 4'd0;
    localparam logic [3:0] ADDR_HEXVAL = 4'd1;
    localparam logic [3:0] ADDR_RAW_LO = 4'd2;
    localparam logic [3:0] ADDR_RAW_HI = 4'd3;
    localparam logic [3:0] ADDR_LEDS   = 4'd4;
    localparam logic [3:0] ADDR_RATE   = 4'd5;
    localparam logic [3:0] ADDR_MSGLEN = 4'd6;
    localparam logic [3:0] ADDR_STATUS = 4'd7;
    localparam logic [3:0] ADDR_MSGDAT = 4'd8;

    localparam int CTRL_MODE      = 0;
    localparam int CTRL_SCROLL    = 1;
    localparam int CTRL_BLINK     = 2;
    localparam int CTRL_BLANK_LSB = 8;

    typedef enum logic {S_IDLE, S_RUN} scroll_state_t;

    // Stored MSGLEN may be 0 or above 16; the scroller always sees 1..16.
    function automatic logic [4:0] clamp_len(input logic [4:0] v);
        if (v == 5'd0)
            return 5'd1;
        else if (v > 5'd16)
            return 5'd16;
        else
            return v;
    endfunction

    function automatic logic [IDX_W-1:0] wrap_idx(input logic [4:0] sum, input logic [4:0] len);
        logic [4:0] r;
        r = sum % len;
        return r[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational hex nibble to active-low gfedcba seven-segment encoder.
module hex7seg_enc
    import debug_disp_pkg::*;
(
    input  logic [3:0]       nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/debug_display_ctrl.sv
// Avalon-MM debug display: hex/raw/scrolling-message drive for HEX0..HEX5 plus LEDR.
// Define DEBUG_DISPLAY_BLINK_EN to build the blink phase flop.
module debug_display_ctrl
    import debug_disp_pkg::*;
#(
    parameter int          CLK_HZ       = 50_000_000,
    parameter logic [15:0] RATE_DEFAULT = 16'd250
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic [41:0] debug_seg_conduit,
    output logic [9:0]  debug_light_conduit
);

    localparam int unsigned PRESC_DIV  = (CLK_HZ / 1000 < 1) ? 1 : CLK_HZ / 1000;
    localparam logic [31:0] PRESC_LAST = 32'(PRESC_DIV - 1);

    // Reset asserts asynchronously and leaves on the second clock edge.
    logic rst_meta, rst_n;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) {rst_meta, rst_n} <= 2'b00;
        else          {rst_meta, rst_n} <= {1'b1, rst_meta};
    end

    logic              mode, scroll_en, blink_en, phase;
    logic [DIGITS-1:0] blank;
    logic [23:0]       hexval;
    logic [27:0]       raw_lo;
    logic [13:0]       raw_hi;
    logic [9:0]        leds;
    logic [15:0]       rate;
    logic [4:0]        msglen, eff_len;
    logic [SEG_W-1:0]  msg [MSG_DEPTH];
    logic              unused_wd;

    logic rate_wr, msglen_wr, rd_en;
    assign rate_wr   = avs_write && (avs_address == ADDR_RATE);
    assign msglen_wr = avs_write && (avs_address == ADDR_MSGLEN);
    assign rd_en     = avs_read && !avs_write;
    assign eff_len   = clamp_len(msglen);
    assign unused_wd = ^avs_writedata[31:28];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode <= 1'b0; scroll_en <= 1'b0; blank <= '0;
            hexval <= '0; raw_lo <= '0; raw_hi <= '0; leds <= '0;
            rate <= RATE_DEFAULT; msglen <= '0;
            for (int i = 0; i < MSG_DEPTH; i++) msg[i] <= '0;
        end else if (avs_write) begin
            case (avs_address)
                ADDR_CTRL: begin
                    mode      <= avs_writedata[CTRL_MODE];
                    scroll_en <= avs_writedata[CTRL_SCROLL];
                    blank     <= avs_writedata[CTRL_BLANK_LSB +: DIGITS];
                end
                ADDR_HEXVAL: hexval <= avs_writedata[23:0];
                ADDR_RAW_LO: raw_lo <= avs_writedata[27:0];
                ADDR_RAW_HI: raw_hi <= avs_writedata[13:0];
                ADDR_LEDS:   leds   <= avs_writedata[9:0];
                ADDR_RATE:   rate   <= avs_writedata[15:0];
                ADDR_MSGLEN: msglen <= avs_writedata[4:0];
                ADDR_MSGDAT: msg[avs_writedata[11:8]] <= avs_writedata[SEG_W-1:0];
                default: ;
            endcase
        end
    end

    // 1 ms tick prescaler and step counter; a RATE write restarts both and swallows that step.
    logic [31:0] presc;
    logic [15:0] rate_cnt, eff_rate;
    logic [16:0] rate_nxt;
    logic        tick, step;
    assign tick     = (presc == PRESC_LAST);
    assign eff_rate = (rate == 16'd0) ? 16'd1 : rate;
    assign rate_nxt = {1'b0, rate_cnt} + 17'd1;
    assign step     = tick && !rate_wr && (rate_nxt >= {1'b0, eff_rate});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0; rate_cnt <= '0;
        end else if (rate_wr) begin
            presc <= '0; rate_cnt <= '0;
        end else begin
            presc <= tick ? 32'd0 : presc + 32'd1;
            if (tick) rate_cnt <= (rate_nxt >= {1'b0, eff_rate}) ? 16'd0 : rate_nxt[15:0];
        end
    end

`ifdef DEBUG_DISPLAY_BLINK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                            blink_en <= 1'b0;
        else if (avs_write && (avs_address == ADDR_CTRL))      blink_en <= avs_writedata[CTRL_BLINK];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        phase <= 1'b1;
        else if (!blink_en) phase <= 1'b1;
        else if (step)      phase <= ~phase;
    end
`else
    assign blink_en = 1'b0;
    assign phase    = 1'b1;
`endif

    scroll_state_t    state, state_nxt;
    logic [IDX_W-1:0] pos, pos_nxt;
    logic [4:0]       pos_inc;
    assign pos_inc = {1'b0, pos} + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE; pos <= '0;
        end else begin
            state <= state_nxt; pos <= pos_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pos_nxt   = pos;
        case (state)
            S_IDLE: if (scroll_en) begin
                state_nxt = S_RUN;
                pos_nxt   = '0;
            end
            S_RUN: begin
                if (!scroll_en)     state_nxt = S_IDLE;
                else if (msglen_wr) pos_nxt = '0;
                else if (step)      pos_nxt = (pos_inc >= eff_len) ? '0 : pos_inc[IDX_W-1:0];
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    logic [SEG_W-1:0] hex_seg [DIGITS];
    for (genvar k = 0; k < DIGITS; k++) begin : g_enc
        hex7seg_enc u_enc (.nibble(hexval[4*k +: 4]), .seg(hex_seg[k]));
    end

    logic [41:0] raw_all, seg_nxt;
    assign raw_all = {raw_hi, raw_lo};

    // HEXk sits at the top of the conduit for k = 0; scroll shows msg[pos] on HEX5.
    always_comb begin : p_mux
        logic [SEG_W-1:0] d;
        seg_nxt = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (state == S_RUN) d = msg[wrap_idx(5'(pos) + 5'(DIGITS - 1 - k), eff_len)];
            else if (mode)      d = raw_all[SEG_W*k +: SEG_W];
            else                d = hex_seg[k];
            if (blank[k] || !phase) d = SEG_BLANK;
            seg_nxt[SEG_W*(DIGITS-1-k) +: SEG_W] = d;
        end
    end

    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = '0;
        case (avs_address)
            ADDR_CTRL: begin
                rd_mux[CTRL_MODE]                 = mode;
                rd_mux[CTRL_SCROLL]               = scroll_en;
                rd_mux[CTRL_BLINK]                = blink_en;
                rd_mux[CTRL_BLANK_LSB +: DIGITS]  = blank;
            end
            ADDR_HEXVAL: rd_mux[23:0] = hexval;
            ADDR_RAW_LO: rd_mux[27:0] = raw_lo;
            ADDR_RAW_HI: rd_mux[13:0] = raw_hi;
            ADDR_LEDS:   rd_mux[9:0]  = leds;
            ADDR_RATE:   rd_mux[15:0] = rate;
            ADDR_MSGLEN: rd_mux[4:0]  = msglen;
            ADDR_STATUS: rd_mux[5:0]  = {phase, state == S_RUN, pos};
            default:     rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avs_readdata        <= '0;
            debug_seg_conduit   <= '1;
            debug_light_conduit <= '0;
        end else begin
            if (rd_en) avs_readdata <= rd_mux;
            debug_seg_conduit   <= seg_nxt;
            debug_light_conduit <= leds;
        end
    end

endmodule
